// File: rtl/adc_sample_uart.sv
// ---------------------------------------------------------------------------
// adc_sample_uart
//
// Buffers 32-bit ADC sample words from the capture stage in a 64-deep
// circular FIFO. Each buffered word is sent out over a UART 8N1 line as a
// 5-byte packet: SYNC_BYTE followed by the word, most significant byte
// first. Each byte goes out LSB first.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active low (0 = reset)
//   word      in   sample word {timestamp[15:0], 4'b0, adc_code[11:0]}
//   wren      in   write strobe; only its rising edge writes
//   tx        out  UART line, registered, idles high
//   busy      out  high while a packet is in flight (LOAD..STOP)
//   level     out  FIFO occupancy, 0..2^ADDR_W
//   overflow  out  sticky; a write was dropped because the FIFO was full
//
// FSM states
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | line idle, waiting for level > 0
//   S_LOAD  | pop one word into the packet shift register (1 cycle)
//   S_START | start bit, tx = 0 for CLK_DIV cycles
//   S_DATA  | 8 data bits of the current byte, LSB first
//   S_STOP  | stop bit, tx = 1; then next byte or back to idle
// ---------------------------------------------------------------------------
module adc_sample_uart #(
    parameter int         WORD_LEN  = 32,
    parameter int         ADDR_W    = 6,
    parameter int         CLK_DIV   = 434,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] word,
    input  logic                wren,
    output logic                tx,
    output logic                busy,
    output logic [ADDR_W:0]     level,
    output logic                overflow
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam int              CNT_W     = $clog2(CLK_DIV);
    localparam int              PKT_W     = WORD_LEN + 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]      LAST_BYTE = 3'(WORD_LEN / 8);
    localparam logic [ADDR_W:0] LVL_FULL  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // -----------------------------------------------------------------------
    // Write-strobe edge detect and FIFO bookkeeping
    // -----------------------------------------------------------------------
    logic                wren_q;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                ovf_q, ovf_d;
    logic [WORD_LEN-1:0] mem_q [DEPTH];
    logic [WORD_LEN-1:0] rdata;

    logic wr_req;
    logic pop;
    logic full;
    logic push;

    state_t state_q, state_d;

    assign wr_req = wren & ~wren_q;
    // LOAD is only ever entered with level > 0, so a pop never underflows.
    assign pop    = (state_q == S_LOAD);
    assign full   = (level_q == LVL_FULL);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push   = wr_req & (~full | pop);
    assign rdata  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        if (wr_req && !push) begin
            ovf_d = 1'b1;
        end
    end

    // Storage is not reset; clearing the pointers and level discards it.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    // -----------------------------------------------------------------------
    // Transmit FSM
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [PKT_W-1:0] sh_q, sh_d;
    logic             tx_q, tx_d;
    logic             cnt_last;
    logic [7:0]       cur_byte;

    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        sh_d     = sh_q;
        cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
        tx_d     = 1'b1;
        cur_byte = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sh_d    = {SYNC_BYTE, rdata};
                byte_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (cnt_last) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_last) begin
                    if (byte_q < LAST_BYTE) begin
                        byte_d  = byte_q + 1'b1;
                        // Next byte moves to the top of the shift register.
                        sh_d    = {sh_q[WORD_LEN-1:0], 8'h00};
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bit timer restarts on every state entry and rests in IDLE/LOAD.
        if (state_d != state_q || state_q == S_IDLE || state_q == S_LOAD) begin
            cnt_d = '0;
        end

        // tx is computed from the next state so the registered line
        // changes on the same edge as the state it belongs to.
        cur_byte = sh_d[PKT_W-1 -: 8];
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wren_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
        end else begin
            wren_q   <= wren;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_adc_sample_uart.sv
// Bench for adc_sample_uart. A cycle-level reference model (word queue plus
// a packet-busy countdown) predicts level/busy/overflow and pushes the
// expected packet bytes into a scoreboard queue; a separate UART monitor
// decodes tx and checks each received byte against that queue.
module tb_adc_sample_uart;

    localparam int CLK_DIV  = 4;
    localparam int DEPTH    = 64;
    localparam int PKT_BITS = 50 * CLK_DIV;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        wren = 1'b0;
    logic [31:0] word = 32'h0;
    logic        tx;
    logic        busy;
    logic [6:0]  level;
    logic        overflow;

    adc_sample_uart #(
        .WORD_LEN (32),
        .ADDR_W   (6),
        .CLK_DIV  (CLK_DIV),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .word    (word),
        .wren    (wren),
        .tx      (tx),
        .busy    (busy),
        .level   (level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model
    logic [31:0] m_q[$];
    logic [7:0]  exp_bytes[$];
    bit          m_ovf       = 1'b0;
    bit          m_wren_prev = 1'b0;
    bit          m_load      = 1'b0;
    int          m_left      = 0;
    int          rst_gen     = 0;

    int busy_cycles = 0;
    int max_level   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge of the model, using the inputs the DUT sees.
    task automatic model_step();
        bit          req;
        bit          go;
        logic [31:0] w;
        if (!rst) begin
            m_q.delete();
            exp_bytes.delete();
            m_ovf       = 1'b0;
            m_wren_prev = 1'b0;
            m_load      = 1'b0;
            m_left      = 0;
            rst_gen++;
        end else begin
            req         = wren && !m_wren_prev;
            m_wren_prev = wren;
            go          = !m_load && (m_left == 0) && (m_q.size() > 0);
            if (m_load) begin
                w = m_q.pop_front();
                exp_bytes.push_back(8'hA5);
                for (int b = 3; b >= 0; b--) exp_bytes.push_back(w[8*b +: 8]);
            end
            if (req) begin
                if (m_q.size() < DEPTH) m_q.push_back(word);
                else m_ovf = 1'b1;
            end
            if (m_load) begin
                m_load = 1'b0;
                m_left = PKT_BITS;
            end else if (m_left > 0) begin
                m_left--;
            end else if (go) begin
                m_load = 1'b1;
            end
        end
    endtask

    task automatic tick();
        bit exp_busy;
        @(posedge clk);
        model_step();
        #1;
        exp_busy = m_load || (m_left > 0);
        check("level", level, m_q.size());
        check("busy", busy, exp_busy);
        check("overflow", overflow, m_ovf);
        if (!exp_busy) check("tx_idle", tx, 1);
        if (busy === 1'b1) busy_cycles++;
        if (int'(level) > max_level) max_level = int'(level);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(!m_load && m_left == 0 && m_q.size() == 0) && n < bound) begin
            tick();
            n++;
        end
        n_vec++;
        if (n >= bound) begin
            n_err++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic wait_load(input int bound);
        int n = 0;
        while (!m_load && n < bound) begin
            tick();
            n++;
        end
        n_vec++;
        if (!m_load) begin
            n_err++;
            $display("FAIL load_timeout: no LOAD after %0d cycles, expected one", n);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // UART monitor / scoreboard consumer
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        logic       st;
        logic       sp;
        int         g;
        prev = 1'b1;
        b    = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (tx === 1'b0 && prev === 1'b1) begin
                g = rst_gen;
                wait_cycles(CLK_DIV / 2);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    wait_cycles(CLK_DIV);
                    b[i] = tx;
                end
                wait_cycles(CLK_DIV);
                sp = tx;
                if (g == rst_gen) begin
                    check("start_bit", st, 0);
                    check("stop_bit", sp, 1);
                    if (exp_bytes.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_unexpected: got byte %02h, expected no byte", b);
                    end else begin
                        check("sb_byte", b, exp_bytes.pop_front());
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin : driver
        // reset state
        repeat (3) tick();
        check("rst_tx", tx, 1);
        rst = 1'b1;
        tick();

        // single sample
        busy_cycles = 0;
        word = 32'h12340ABC;
        wren = 1'b1;
        tick();
        wren = 1'b0;
        wait_idle(1000);
        check("t1_busy_len", busy_cycles, 1 + PKT_BITS);

        // held strobe
        max_level = 0;
        word = 32'hDEADBEEF;
        wren = 1'b1;
        repeat (20) tick();
        wren = 1'b0;
        wait_idle(1000);
        check("t2_max_level", max_level, 1);

        // random words with random strobe widths and gaps
        repeat (12) begin
            word = $urandom;
            wren = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            wren = 1'b0;
            repeat ($urandom_range(1, 260)) tick();
        end
        wait_idle(20000);

        // overflow: 66 pulses, word 0 popped, 1..64 fill, 65 dropped
        rst = 1'b0;
        tick();
        rst = 1'b1;
        max_level = 0;
        for (int i = 0; i < 66; i++) begin
            word = i;
            wren = 1'b1;
            tick();
            wren = 1'b0;
            tick();
        end
        check("t4_overflow", overflow, 1);
        check("t4_level", level, 64);
        check("t4_peak", max_level, 64);

        // reset during DATA of byte 2 of the next packet
        wait_load(1000);
        repeat (95) tick();
        rst = 1'b0;
        tick();
        check("t5_tx", tx, 1);
        check("t5_busy", busy, 0);
        check("t5_level", level, 0);
        check("t5_ovf", overflow, 0);
        rst = 1'b1;
        repeat (300) tick();

        // fill to 64, then write in the LOAD cycle
        for (int i = 0; i < 65; i++) begin
            word = 32'h100 + i;
            wren = 1'b1;
            tick();
            wren = 1'b0;
            tick();
        end
        check("t6_full", level, 64);
        wait_load(1000);
        word = $urandom;
        wren = 1'b1;
        tick();
        wren = 1'b0;
        check("t6_level", level, 64);
        check("t6_ovf", overflow, 0);
        wait_idle(20000);

        // wren held high across reset release
        rst  = 1'b0;
        word = $urandom;
        wren = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        busy_cycles = 0;
        max_level   = 0;
        repeat (5) tick();
        wren = 1'b0;
        wait_idle(1000);
        check("t7_max_level", max_level, 1);
        check("t7_busy_len", busy_cycles, 1 + PKT_BITS);

        repeat (20) tick();
        check("sb_leftover", exp_bytes.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
